branch_predictor_2bit: RTL and testbench

- Fetch-side branch predictor plus branch target buffer (BTB).
- It supplies the predicted next PC for the IF stage.
- It is trained by branch/jump resolution from the EX stage.
- The hazard unit's EX-stage next-PC compare and mispredict flush (comp_o, PC_jump_EX) checks what this block predicts.

---
 rtl/branch_predictor_2bit_if.sv | 27 ++
 rtl/branch_predictor_2bit.sv | 107 ++++++++++
 tb/tb_branch_predictor_2bit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_2bit_if.sv
// Fetch/execute-side bundle of the 2-bit branch predictor: IF lookup, EX training, perf counters.
// The slave modport is the predictor; the master modport is the pipeline driving it.
interface branch_predictor_2bit_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      pc_IF;
    logic             pred_taken_IF;
    logic [31:0]      pred_pc_IF;
    logic             upd_valid_EX;
    logic [6:0]       op_ex;
    logic [31:0]      pc_EX;
    logic             taken_EX;
    logic [31:0]      target_EX;
    logic             comp_o;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    modport slave (
        input  pc_IF, upd_valid_EX, op_ex, pc_EX, taken_EX, target_EX, comp_o,
        output pred_taken_IF, pred_pc_IF, br_count, mp_count
    );

    modport master (
        output pc_IF, upd_valid_EX, op_ex, pc_EX, taken_EX, target_EX, comp_o,
        input  pred_taken_IF, pred_pc_IF, br_count, mp_count
    );
endinterface

// File: rtl/branch_predictor_2bit.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency lookup on pc_IF,
// single-edge training from EX, no backpressure; lookup never sees a same-cycle update.
module branch_predictor_2bit #(
    parameter int ENTRIES = 64,
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 32
) (
    input logic                    clk,
    input logic                    rst,
    branch_predictor_2bit_if.slave bp
);
    localparam int TAG_W = 30 - INDEX_W;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [CNT_W-1:0]   br_count_q, br_count_d;
    logic [CNT_W-1:0]   mp_count_q, mp_count_d;

    logic [INDEX_W-1:0] idx_if, idx_ex;
    logic [TAG_W-1:0]   tag_if, tag_ex;
    logic               hit_if, hit_ex;
    logic               is_branch, is_jump, upd_en;
    logic               wr_en;
    logic [1:0]         wr_ctr;
    logic [31:0]        wr_target;
    logic               unused_pc_lsbs;

    assign idx_if = bp.pc_IF[INDEX_W+1:2];
    assign tag_if = bp.pc_IF[31:INDEX_W+2];
    assign idx_ex = bp.pc_EX[INDEX_W+1:2];
    assign tag_ex = bp.pc_EX[31:INDEX_W+2];
    assign unused_pc_lsbs = ^{bp.pc_IF[1:0], bp.pc_EX[1:0]};

    assign hit_if           = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    assign bp.pred_taken_IF = hit_if && ctr_q[idx_if][1];
    assign bp.pred_pc_IF    = bp.pred_taken_IF ? target_q[idx_if] : bp.pc_IF + 32'd4;

    assign is_branch = (bp.op_ex == OP_BRANCH);
    assign is_jump   = (bp.op_ex == OP_JAL) || (bp.op_ex == OP_JALR);
    assign upd_en    = bp.upd_valid_EX && (is_branch || is_jump);
    assign hit_ex    = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

    always_comb begin
        wr_en     = 1'b0;
        wr_ctr    = ctr_q[idx_ex];
        wr_target = target_q[idx_ex];
        if (upd_en) begin
            if (is_jump) begin
                wr_en     = 1'b1;
                wr_ctr    = 2'b11;
                wr_target = bp.target_EX;
            end else if (hit_ex) begin
                wr_en = 1'b1;
                if (bp.taken_EX) begin
                    wr_target = bp.target_EX;
                    if (ctr_q[idx_ex] != 2'b11) wr_ctr = ctr_q[idx_ex] + 2'd1;
                end else if (ctr_q[idx_ex] != 2'b00) begin
                    wr_ctr = ctr_q[idx_ex] - 2'd1;
                end
            end else if (bp.taken_EX) begin
                // Taken miss evicts whatever aliases this index.
                wr_en     = 1'b1;
                wr_ctr    = 2'b10;
                wr_target = bp.target_EX;
            end
        end
    end

    always_comb begin
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (upd_en && (br_count_q != {CNT_W{1'b1}})) br_count_d = br_count_q + 1'b1;
        if (upd_en && bp.comp_o && (mp_count_q != {CNT_W{1'b1}})) mp_count_d = mp_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            br_count_q <= '0;
            mp_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else begin
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
            if (wr_en) begin
                valid_q[idx_ex] <= 1'b1;
                ctr_q[idx_ex]   <= wr_ctr;
            end
        end
    end

    // Tag/target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[idx_ex]    <= tag_ex;
            target_q[idx_ex] <= wr_target;
        end
    end

    assign bp.br_count = br_count_q;
    assign bp.mp_count = mp_count_q;
endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Directed bench for branch_predictor_2bit: training, saturation, aliasing, same-cycle hazard, counters, reset.
module tb_branch_predictor_2bit;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    branch_predictor_2bit_if #(.CNT_W(32)) bp ();

    branch_predictor_2bit #(.ENTRIES(64), .INDEX_W(6), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pred(input string name, input logic [31:0] pc, input logic tk, input logic [31:0] npc);
        bp.pc_IF = pc;
        #1;
        chk({name, "_taken"}, {31'd0, bp.pred_taken_IF}, {31'd0, tk});
        chk({name, "_pc"}, bp.pred_pc_IF, npc);
        @(negedge clk);
    endtask

    task automatic upd(input logic [6:0] op, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic cmp);
        bp.upd_valid_EX = 1'b1;
        bp.op_ex        = op;
        bp.pc_EX        = pc;
        bp.taken_EX     = tk;
        bp.target_EX    = tgt;
        bp.comp_o       = cmp;
        tick();
        bp.upd_valid_EX = 1'b0;
        bp.comp_o       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk           = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bp.pc_IF        = 32'h100;
        bp.upd_valid_EX = 1'b0;
        bp.op_ex        = OP_ALU;
        bp.pc_EX        = 32'h0;
        bp.taken_EX     = 1'b0;
        bp.target_EX    = 32'h0;
        bp.comp_o       = 1'b0;
        #1;
        chk("rst_taken", {31'd0, bp.pred_taken_IF}, 32'd0);
        chk("rst_pc", bp.pred_pc_IF, 32'h104);
        chk("rst_br", bp.br_count, 32'd0);
        chk("rst_mp", bp.mp_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Cold miss, allocate, then walk the counter down and back up.
        pred("cold", 32'h100, 1'b0, 32'h104);
        upd(OP_BR, 32'h100, 1'b1, 32'h80, 1'b0);
        pred("alloc", 32'h100, 1'b1, 32'h80);
        upd(OP_BR, 32'h100, 1'b0, 32'h0, 1'b0);
        pred("nt1", 32'h100, 1'b0, 32'h104);
        upd(OP_BR, 32'h100, 1'b0, 32'h0, 1'b0);
        pred("nt2", 32'h100, 1'b0, 32'h104);
        upd(OP_BR, 32'h100, 1'b0, 32'h0, 1'b0);
        pred("nt3", 32'h100, 1'b0, 32'h104);
        upd(OP_BR, 32'h100, 1'b1, 32'h80, 1'b0);
        pred("floor_t1", 32'h100, 1'b0, 32'h104);
        upd(OP_BR, 32'h100, 1'b1, 32'h80, 1'b0);
        pred("floor_t2", 32'h100, 1'b1, 32'h80);

        // 0x200 shares index 0 with 0x100; saturate high.
        upd(OP_BR, 32'h200, 1'b1, 32'h240, 1'b0);
        pred("sat_alloc", 32'h200, 1'b1, 32'h240);
        pred("sat_evict", 32'h100, 1'b0, 32'h104);
        upd(OP_BR, 32'h200, 1'b1, 32'h240, 1'b0);
        upd(OP_BR, 32'h200, 1'b1, 32'h240, 1'b0);
        upd(OP_BR, 32'h200, 1'b1, 32'h240, 1'b0);
        upd(OP_BR, 32'h200, 1'b0, 32'h0, 1'b0);
        pred("sat_nt1", 32'h200, 1'b1, 32'h240);
        upd(OP_BR, 32'h200, 1'b0, 32'h0, 1'b0);
        pred("sat_nt2", 32'h200, 1'b0, 32'h204);

        // Alias: JAL then taken branch on the same index.
        upd(OP_JAL, 32'h100, 1'b1, 32'h300, 1'b0);
        pred("jal", 32'h100, 1'b1, 32'h300);
        pred("jal_evict", 32'h200, 1'b0, 32'h204);
        upd(OP_BR, 32'h200, 1'b1, 32'h500, 1'b0);
        pred("alias_miss", 32'h100, 1'b0, 32'h104);
        pred("alias_new", 32'h200, 1'b1, 32'h500);

        // Same-cycle lookup and allocation: no bypass.
        bp.upd_valid_EX = 1'b1;
        bp.op_ex        = OP_BR;
        bp.pc_EX        = 32'h400;
        bp.taken_EX     = 1'b1;
        bp.target_EX    = 32'h480;
        bp.pc_IF        = 32'h400;
        #1;
        chk("haz_same_taken", {31'd0, bp.pred_taken_IF}, 32'd0);
        chk("haz_same_pc", bp.pred_pc_IF, 32'h404);
        tick();
        bp.upd_valid_EX = 1'b0;
        pred("haz_next", 32'h400, 1'b1, 32'h480);

        // Not-taken miss must not allocate.
        upd(OP_BR, 32'h10C, 1'b0, 32'h900, 1'b0);
        pred("nt_noalloc", 32'h10C, 1'b0, 32'h110);
        chk("br_mid", bp.br_count, 32'd16);
        chk("mp_mid", bp.mp_count, 32'd0);

        // Reset pulsed between edges, with an update pending across the edge.
        bp.upd_valid_EX = 1'b1;
        bp.op_ex        = OP_JAL;
        bp.pc_EX        = 32'h600;
        bp.taken_EX     = 1'b1;
        bp.target_EX    = 32'h680;
        bp.comp_o       = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_br", bp.br_count, 32'd0);
        chk("rst_async_mp", bp.mp_count, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst             = 1'b0;
        bp.upd_valid_EX = 1'b0;
        bp.comp_o       = 1'b0;
        pred("rst_discard", 32'h600, 1'b0, 32'h604);
        pred("rst_clear", 32'h200, 1'b0, 32'h204);
        chk("rst_discard_br", bp.br_count, 32'd0);

        // Counters: 5 control-flow (2 mispredicted), plus ignored ops.
        upd(OP_JALR, 32'h700, 1'b1, 32'h7F0, 1'b1);
        upd(OP_BR,   32'h704, 1'b1, 32'h7A0, 1'b0);
        upd(OP_ALU,  32'h708, 1'b1, 32'hA00, 1'b1);
        upd(OP_BR,   32'h708, 1'b0, 32'h0,   1'b1);
        upd(OP_JAL,  32'h70C, 1'b1, 32'h800, 1'b0);
        bp.op_ex  = OP_BR;
        bp.comp_o = 1'b1;
        tick();
        bp.comp_o = 1'b0;
        upd(OP_BR,   32'h704, 1'b0, 32'h0,   1'b0);
        chk("cnt_br", bp.br_count, 32'd5);
        chk("cnt_mp", bp.mp_count, 32'd2);
        pred("jalr", 32'h700, 1'b1, 32'h7F0);
        pred("br_dec", 32'h704, 1'b0, 32'h708);
        pred("alu_noalloc", 32'h708, 1'b0, 32'h70C);
        pred("jal_2", 32'h70C, 1'b1, 32'h800);

        #2;
        rst = 1'b1;
        #1;
        chk("rst2_br", bp.br_count, 32'd0);
        chk("rst2_mp", bp.mp_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
